ram_arbiter: RTL
================

// Module: ram_arbiter
// PURPOSE
//  Shares the single-port program/data RAM between two requesters: CPU (port 0) and program loader (port 1).
//  Sequences each access through the RAM's registered-address protocol: load address, then read or write.
//  Returns read data with a one-cycle ack pulse. Sits between the requesters and the RAM block.
// PARAMETERS
//  ADDR_W      8  RAM address width (select bit excluded)
//  DATA_W      8  data width
//  FIXED_PRIO  0  0: round-robin between ports; 1: CPU always wins on contention
// PORTS
//  i_clk           in   1       clock, all state on rising edge
//  i_nReset        in   1       asynchronous, active-low reset
//  i_cpuReq        in   1       CPU request; held with its fields stable until o_cpuAck
//  i_cpuWe         in   1       1 write, 0 read
//  i_cpuSel        in   1       1 data half, 0 program half
//  i_cpuAddr       in   ADDR_W  access address
//  i_cpuWData      in   DATA_W  write data
//  o_cpuAck        out  1       one-cycle completion pulse
//  o_cpuRData      out  DATA_W  read data, valid while o_cpuAck=1
//  i_ldReq/i_ldWe/i_ldSel/i_ldAddr/i_ldWData, o_ldAck/o_ldRData   same as CPU port, loader side
//  o_ramAddress    out  ADDR_W  address to RAM address register
//  o_ramAddressEn  out  1       load RAM address register
//  o_ramWriteData  out  DATA_W  RAM write data
//  o_ramWriteEn    out  1       RAM write strobe
//  o_ramSelect     out  1       RAM program/data select
//  o_ramOutEnable  out  1       RAM read driver enable
//  i_ramReadData   in   DATA_W  RAM read data (combinational from RAM registered address)
// BEHAVIOUR
//  Reset (async assert): state IDLE; all outputs 0; addr-valid cleared; rr pointer -> loader (CPU wins first tie).
//  States: IDLE, ADDR, ACCESS, RESP.
//  IDLE: if any req, latch the winner's index, we, sel, addr and wdata into a grant register.
//   If addr-valid and addr == last loaded address, go to ACCESS. Otherwise go to ADDR. No req: stay in IDLE.
//  ADDR (1 cycle): o_ramAddressEn=1, o_ramAddress=latched addr. At the edge, record last address and set addr-valid.
//  ACCESS (1 cycle): o_ramSelect=latched sel.
//   Write: o_ramWriteEn=1, o_ramWriteData=latched wdata.
//   Read: o_ramOutEnable=1; capture i_ramReadData at the edge.
//  RESP (1 cycle): pulse the granted port's ack; its RData = captured data (reads), 0 (writes). Next state: IDLE.
//  Latency, req sampled at edge E in IDLE: ack high in cycle E+3 (miss) or E+2 (address hit).
//  Handshake: a requester drops req, or presents a new request, no earlier than the cycle after ack.
//   req still high in IDLE is a new transaction.
//  Select is not part of the hit compare: the RAM applies select combinationally.
//  Arbitration happens only in IDLE; a pending request is never preempted mid-transaction.
//  Contention, FIXED_PRIO=0: grant the port not granted last; pointer updates on every grant.
//  Contention, FIXED_PRIO=1: CPU always granted; loader waits.
//  RAM strobes (AddressEn, WriteEn, OutEnable) are mutually exclusive and each at most 1 cycle per transaction.
//  They are never asserted in IDLE or RESP.
//  Outputs are registered from the state/grant register; no combinational req->ram path.
//  Reset mid-transaction: strobes drop immediately, no ack issued, addr-valid cleared.
//   A write is lost if reset asserts before its ACCESS edge.
//  Addr-valid is also cleared whenever reset is released. The RAM address register resets to all-ones independently.
// STRUCTURE
//  Package edic_ram_pkg: state enum ram_arb_state_e {IDLE,ADDR,ACCESS,RESP}; localparams PORT_CPU=0, PORT_LD=1.
//  Sub-module rr_arb2: 2-way grant logic (req[1:0], FIXED_PRIO, pointer -> one-hot grant), instantiated once.
//  Remaining logic (FSM, grant register, hit compare, response mux) stays in ram_arbiter.
// TESTING
//  1. RAM data[0x10]=0xA5; CPU read sel=1 addr 0x10 after reset -> AddressEn 1 cycle; ack at E+3; o_cpuRData=0xA5.
//  2. CPU write 0x3C to data[0x20], then read 0x20 -> write ack at E+3; read is a hit, no AddressEn, ack at E+2, 0x3C.
//  3. Same addr 0x20, read sel=0 after case 2 -> hit, no AddressEn; returns program[0x20].
//  4. Both reqs held continuously, FIXED_PRIO=0 -> acks alternate CPU, LD, CPU, LD; never two acks in one cycle.
//  5. Same as 4 with FIXED_PRIO=1 -> only CPU acks while i_cpuReq stays high; loader acked on the first IDLE with CPU idle.
//  6. i_nReset low during ACCESS of a loader write to 0x05 -> WriteEn drops same cycle, no ack, data[0x05] unchanged.
//     Next access to 0x05 is a miss (AddressEn pulsed).

Source files
------------

// File: rtl/edic_ram_pkg.sv
// Shared types for the RAM arbiter slice.
// Holds the arbiter FSM states and port indices.
`timescale 1ns/1ps
package edic_ram_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    ACCESS,
    RESP
  } ram_arb_state_e;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_LD  = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way grant logic: round-robin or fixed CPU priority.
// ptr holds the index of the port granted last.
`timescale 1ns/1ps
module rr_arb2 #(
  parameter int FIXED_PRIO = 0
) (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] gnt
);

  // One-hot grant; on contention pick by mode
  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      if (FIXED_PRIO != 0) begin
        gnt = 2'b01;
      end else begin
        gnt = ptr ? 2'b01 : 2'b10;
      end
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Shares the single-port program/data RAM between CPU and loader.
// Sequences address load, then read or write, then a one-cycle ack.
`timescale 1ns/1ps
module ram_arbiter #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 8,
  parameter int FIXED_PRIO = 0
) (
  input  logic              i_clk,
  input  logic              i_nReset,
  input  logic              i_cpuReq,
  input  logic              i_cpuWe,
  input  logic              i_cpuSel,
  input  logic [ADDR_W-1:0] i_cpuAddr,
  input  logic [DATA_W-1:0] i_cpuWData,
  output logic              o_cpuAck,
  output logic [DATA_W-1:0] o_cpuRData,
  input  logic              i_ldReq,
  input  logic              i_ldWe,
  input  logic              i_ldSel,
  input  logic [ADDR_W-1:0] i_ldAddr,
  input  logic [DATA_W-1:0] i_ldWData,
  output logic              o_ldAck,
  output logic [DATA_W-1:0] o_ldRData,
  output logic [ADDR_W-1:0] o_ramAddress,
  output logic              o_ramAddressEn,
  output logic [DATA_W-1:0] o_ramWriteData,
  output logic              o_ramWriteEn,
  output logic              o_ramSelect,
  output logic              o_ramOutEnable,
  input  logic [DATA_W-1:0] i_ramReadData
);

  import edic_ram_pkg::*;

  ram_arb_state_e state_q, state_d;

  logic              g_port;
  logic              g_we;
  logic              g_sel;
  logic [ADDR_W-1:0] g_addr;
  logic [DATA_W-1:0] g_wdata;
  logic [ADDR_W-1:0] last_addr;
  logic              addr_valid;
  logic              rr_ptr;
  logic [DATA_W-1:0] rdata_q;

  logic [1:0]        req;
  logic [1:0]        gnt;
  logic              win;
  logic [ADDR_W-1:0] win_addr;
  logic              hit;
  logic              take;
  logic              acc;
  logic              resp;
  logic [DATA_W-1:0] rsp_data;

  assign req      = {i_ldReq, i_cpuReq};
  assign win      = gnt[1];
  assign win_addr = win ? i_ldAddr : i_cpuAddr;
  assign hit      = addr_valid && (win_addr == last_addr);
  assign take     = (state_q == IDLE) && (|req);

  rr_arb2 #(
    .FIXED_PRIO(FIXED_PRIO)
  ) u_arb (
    .req(req),
    .ptr(rr_ptr),
    .gnt(gnt)
  );

  // State register
  always_ff @(posedge i_clk or negedge i_nReset) begin
    if (!i_nReset) state_q <= IDLE;
    else           state_q <= state_d;
  end

  // Next state: skip address load on a hit
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (|req) state_d = hit ? ACCESS : ADDR;
      ADDR:    state_d = ACCESS;
      ACCESS:  state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Grant register and round-robin pointer, loaded only in IDLE
  always_ff @(posedge i_clk or negedge i_nReset) begin
    if (!i_nReset) begin
      g_port  <= PORT_CPU;
      g_we    <= 1'b0;
      g_sel   <= 1'b0;
      g_addr  <= '0;
      g_wdata <= '0;
      rr_ptr  <= PORT_LD;
    end else if (take) begin
      g_port  <= win;
      g_we    <= win ? i_ldWe    : i_cpuWe;
      g_sel   <= win ? i_ldSel   : i_cpuSel;
      g_addr  <= win_addr;
      g_wdata <= win ? i_ldWData : i_cpuWData;
      rr_ptr  <= win;
    end
  end

  // Track what the RAM address register holds
  always_ff @(posedge i_clk or negedge i_nReset) begin
    if (!i_nReset) begin
      last_addr  <= '0;
      addr_valid <= 1'b0;
    end else if (state_q == ADDR) begin
      last_addr  <= g_addr;
      addr_valid <= 1'b1;
    end
  end

  // Capture read data at the end of ACCESS
  always_ff @(posedge i_clk or negedge i_nReset) begin
    if (!i_nReset)                       rdata_q <= '0;
    else if (state_q == ACCESS && !g_we) rdata_q <= i_ramReadData;
  end

  assign acc  = (state_q == ACCESS);
  assign resp = (state_q == RESP);

  assign o_ramAddressEn = (state_q == ADDR);
  assign o_ramAddress   = o_ramAddressEn ? g_addr : '0;
  assign o_ramSelect    = acc ? g_sel : 1'b0;
  assign o_ramWriteEn   = acc & g_we;
  assign o_ramWriteData = o_ramWriteEn ? g_wdata : '0;
  assign o_ramOutEnable = acc & ~g_we;

  assign rsp_data   = g_we ? '0 : rdata_q;
  assign o_cpuAck   = resp & (g_port == PORT_CPU);
  assign o_ldAck    = resp & (g_port == PORT_LD);
  assign o_cpuRData = o_cpuAck ? rsp_data : '0;
  assign o_ldRData  = o_ldAck  ? rsp_data : '0;

endmodule
